// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write port,
// optional same-cycle write forwarding and per-register pending (scoreboard) bits.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_reg_a,
    input  logic [ADDR_W-1:0] read_reg_b,
    output logic [WIDTH-1:0]  read_data_a,
    output logic [WIDTH-1:0]  read_data_b,
    input  logic              mark_enable,
    input  logic [ADDR_W-1:0] mark_reg,
    input  logic              flush,
    output logic              pending_a,
    output logic              pending_b
);

    // An address is usable only inside DEPTH and, with ZERO_REG, not register 0.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(DEPTH)) && !(ZERO_REG && (addr == '0));
    endfunction

    logic                         write_valid;
    logic                         mark_valid;
    logic [DEPTH-1:0][WIDTH-1:0]  word_vec;
    logic [DEPTH-1:0]             pending_vec;

    assign write_valid = write_enable && addr_valid(write_reg);
    assign mark_valid  = mark_enable && addr_valid(mark_reg);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;
            logic             pending_reg;

            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    word_reg <= '0;
                end else if (write_valid && (write_reg == ADDR_W'(gi))) begin
                    word_reg <= write_data;
                end
            end

            // flush beats a new producer, which beats the retiring write
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    pending_reg <= 1'b0;
                end else if (flush) begin
                    pending_reg <= 1'b0;
                end else if (mark_valid && (mark_reg == ADDR_W'(gi))) begin
                    pending_reg <= 1'b1;
                end else if (write_valid && (write_reg == ADDR_W'(gi))) begin
                    pending_reg <= 1'b0;
                end
            end

            assign word_vec[gi]    = word_reg;
            assign pending_vec[gi] = pending_reg;
        end

        for (genvar gp = 0; gp < 2; gp++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic [WIDTH-1:0]  data_mux;
            logic              pend_mux;

            assign addr = (gp == 0) ? read_reg_a : read_reg_b;

            // Outputs are held at zero while clear is asserted, even if a write is forwarded.
            always_comb begin
                data_mux = '0;
                pend_mux = 1'b0;
                if (!clear && addr_valid(addr)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (addr == ADDR_W'(i)) begin
                            data_mux = word_vec[i];
                            pend_mux = pending_vec[i];
                        end
                    end
                    if (BYPASS && write_valid && (write_reg == addr)) begin
                        data_mux = write_data;
                        pend_mux = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign read_data_a = g_port[0].data_mux;
    assign read_data_b = g_port[1].data_mux;
    assign pending_a   = g_port[0].pend_mux;
    assign pending_b   = g_port[1].pend_mux;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives three register file configurations (default, no bypass, 16 registers)
// with shared stimulus and checks them against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        clear;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_a;
    logic [4:0]  read_reg_b;
    logic        mark_enable;
    logic [4:0]  mark_reg;
    logic        flush;

    logic [31:0] rd_a [3];
    logic [31:0] rd_b [3];
    logic        pa   [3];
    logic        pb   [3];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [3][32];
    logic        m_pend [3][32];

    always #5 clock = ~clock;

    regfile_scoreboard u0 (
        .clock(clock), .clear(clear), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
        .read_data_a(rd_a[0]), .read_data_b(rd_b[0]), .mark_enable(mark_enable),
        .mark_reg(mark_reg), .flush(flush), .pending_a(pa[0]), .pending_b(pb[0])
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u1 (
        .clock(clock), .clear(clear), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
        .read_data_a(rd_a[1]), .read_data_b(rd_b[1]), .mark_enable(mark_enable),
        .mark_reg(mark_reg), .flush(flush), .pending_a(pa[1]), .pending_b(pb[1])
    );

    regfile_scoreboard #(.DEPTH(16)) u2 (
        .clock(clock), .clear(clear), .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
        .read_data_a(rd_a[2]), .read_data_b(rd_b[2]), .mark_enable(mark_enable),
        .mark_reg(mark_reg), .flush(flush), .pending_a(pa[2]), .pending_b(pb[2])
    );

    function automatic int cfg_depth(input int c);
        return (c == 2) ? 16 : 32;
    endfunction

    function automatic bit cfg_bypass(input int c);
        return (c != 1);
    endfunction

    function automatic bit valid(input int c, input logic [4:0] a);
        return (int'(a) < cfg_depth(c)) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
        if (clear || !valid(c, a)) return 32'd0;
        if (cfg_bypass(c) && write_enable && valid(c, write_reg) && write_reg == a)
            return write_data;
        return m_regs[c][a];
    endfunction

    function automatic logic exp_pend(input int c, input logic [4:0] a);
        if (clear || !valid(c, a)) return 1'b0;
        if (cfg_bypass(c) && write_enable && valid(c, write_reg) && write_reg == a)
            return 1'b0;
        return m_pend[c][a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) begin
                m_regs[c][r] = 32'd0;
                m_pend[c][r] = 1'b0;
            end
    endtask

    task automatic model_update();
        if (clear) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            if (write_enable && valid(c, write_reg)) begin
                m_regs[c][write_reg] = write_data;
                m_pend[c][write_reg] = 1'b0;
            end
            if (mark_enable && valid(c, mark_reg)) m_pend[c][mark_reg] = 1'b1;
            if (flush)
                for (int r = 0; r < 32; r++) m_pend[c][r] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("u%0d data_a r%0d", c, read_reg_a), rd_a[c], exp_data(c, read_reg_a));
            check($sformatf("u%0d data_b r%0d", c, read_reg_b), rd_b[c], exp_data(c, read_reg_b));
            check($sformatf("u%0d pend_a r%0d", c, read_reg_a), {31'd0, pa[c]},
                  {31'd0, exp_pend(c, read_reg_a)});
            check($sformatf("u%0d pend_b r%0d", c, read_reg_b), {31'd0, pb[c]},
                  {31'd0, exp_pend(c, read_reg_b)});
            $display("cyc t=%0t u%0d we=%b wr=%0d ra=%0d rb=%0d mk=%b/%0d fl=%b clr=%b a=%h b=%h pa=%b pb=%b",
                     $time, c, write_enable, write_reg, read_reg_a, read_reg_b, mark_enable,
                     mark_reg, flush, clear, rd_a[c], rd_b[c], pa[c], pb[c]);
        end
    endtask

    // Compare between edges, then advance the model on the edge; returns just after it.
    task automatic cycle();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        mark_enable  = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        idle();
        write_reg = 5'd0; write_data = 32'd0; mark_reg = 5'd0;
        read_reg_a = 5'd0; read_reg_b = 5'd1;
        model_clear();
        #2;
        compare_all();
        cycle();
        clear = 1'b0;
        cycle();

        // Load registers 1..31 with nonzero values and scatter some marks.
        for (int i = 1; i < 32; i++) begin
            write_enable = 1'b1; write_reg = 5'(i); write_data = $urandom | 32'd1;
            read_reg_a = 5'(i); read_reg_b = 5'(i - 1);
            mark_enable = (i % 3 == 0); mark_reg = 5'((i + 5) % 32);
            cycle();
        end
        idle();

        // Clear asserted mid-cycle during a forwarded write.
        write_enable = 1'b1; write_reg = 5'd12; write_data = 32'h7777_0001;
        read_reg_a = 5'd12; read_reg_b = 5'd3;
        #1;
        check("pre-clear r3 nonzero", {31'd0, (rd_b[0] != 32'd0)}, 32'd1);
        clear = 1'b1;
        model_clear();
        #1;
        check("clear data_a", rd_a[0], 32'd0);
        check("clear pend_b", {31'd0, pb[0]}, 32'd0);
        compare_all();
        cycle();
        clear = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            read_reg_a = 5'(i); read_reg_b = 5'(31 - i);
            cycle();
        end

        // Plain write then read; zero register ignores writes.
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        cycle();
        write_reg = 5'd0; write_data = 32'h0000_1234; read_reg_a = 5'd5;
        #2;
        check("r5 read", rd_a[0], 32'hDEAD_BEEF);
        check("model r5", exp_data(0, 5'd5), 32'hDEAD_BEEF);
        cycle();
        idle(); read_reg_a = 5'd0;
        #2;
        check("r0 read", rd_a[0], 32'd0);
        cycle();

        // Forwarding on both ports, and the non-forwarding instance.
        write_enable = 1'b1; write_reg = 5'd7; write_data = 32'h1111_1111;
        cycle();
        write_data = 32'hA5A5_A5A5; read_reg_a = 5'd7; read_reg_b = 5'd7;
        #2;
        check("bypass a", rd_a[0], 32'hA5A5_A5A5);
        check("bypass b", rd_b[0], 32'hA5A5_A5A5);
        check("nobypass a", rd_a[1], 32'h1111_1111);
        check("nobypass b", rd_b[1], 32'h1111_1111);
        cycle();
        idle();
        #2;
        check("nobypass after edge", rd_a[1], 32'hA5A5_A5A5);
        cycle();

        // Pending bit set by mark, cleared by write, kept by simultaneous mark+write.
        mark_enable = 1'b1; mark_reg = 5'd9;
        cycle();
        idle(); read_reg_a = 5'd9;
        #2;
        check("r9 pending", {31'd0, pa[0]}, 32'd1);
        cycle();
        write_enable = 1'b1; write_reg = 5'd9; write_data = $urandom;
        #2;
        check("r9 bypass pend", {31'd0, pa[0]}, 32'd0);
        check("r9 nobypass pend", {31'd0, pa[1]}, 32'd1);
        cycle();
        idle();
        #2;
        check("r9 retired", {31'd0, pa[0]}, 32'd0);
        check("r9 retired nb", {31'd0, pa[1]}, 32'd0);
        cycle();
        mark_enable = 1'b1; mark_reg = 5'd9; write_enable = 1'b1; write_reg = 5'd9;
        cycle();
        idle();
        #2;
        check("r9 mark wins", {31'd0, pa[0]}, 32'd1);
        cycle();

        // Flush drops existing bits and a same-cycle mark.
        mark_enable = 1'b1; mark_reg = 5'd3; cycle();
        mark_reg = 5'd4; cycle();
        mark_reg = 5'd6; cycle();
        idle(); read_reg_a = 5'd3; read_reg_b = 5'd4;
        #2;
        check("r3 marked", {31'd0, pa[0]}, 32'd1);
        check("r4 marked", {31'd0, pb[0]}, 32'd1);
        flush = 1'b1; mark_enable = 1'b1; mark_reg = 5'd8;
        cycle();
        idle();
        #2;
        check("r3 flushed", {31'd0, pa[0]}, 32'd0);
        check("r4 flushed", {31'd0, pb[0]}, 32'd0);
        cycle();
        read_reg_a = 5'd6; read_reg_b = 5'd8;
        #2;
        check("r6 flushed", {31'd0, pa[0]}, 32'd0);
        check("r8 dropped", {31'd0, pb[0]}, 32'd0);
        cycle();

        // Out-of-range register on the 16-entry instance.
        write_enable = 1'b1; write_reg = 5'd20; write_data = 32'hCAFE_F00D;
        mark_enable = 1'b1; mark_reg = 5'd20;
        cycle();
        idle(); read_reg_a = 5'd20; read_reg_b = 5'd20;
        #2;
        check("d16 r20 data", rd_a[2], 32'd0);
        check("d16 r20 pend", {31'd0, pa[2]}, 32'd0);
        check("d32 r20 data", rd_a[0], 32'hCAFE_F00D);
        check("d32 r20 pend", {31'd0, pb[0]}, 32'd1);
        cycle();
        for (int i = 0; i < 16; i++) begin
            read_reg_a = 5'(i); read_reg_b = 5'(15 - i);
            cycle();
        end

        // Randomized traffic with biased address collisions.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                clear = 1'b1;
                model_clear();
            end else begin
                clear = 1'b0;
            end
            write_enable = 1'($urandom_range(0, 1));
            write_reg    = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            read_reg_a   = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg_b   = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            mark_enable  = ($urandom_range(0, 2) == 0);
            mark_reg     = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            flush        = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clear = 1'b0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
